// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared bomb bus state encodings and widths
// Puzzle modules decode current_state with these same constants.
package bomb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'b000,
      ST_ACTIVATING = 3'b001,
      ST_ACTIVATED  = 3'b010,
      ST_DEFUSED    = 3'b011,
      ST_EXPLODED   = 3'b100
   } state_t;

   localparam int TIME_W   = 10;
   localparam int STRIKE_W = 2;

endpackage

// File: rtl/bomb_game_ctrl_if.sv
// rtl/bomb_game_ctrl_if.sv - broadcast state bus and per-module handshake lines
// master = game sequencer, slave = puzzle module array.
interface bomb_game_ctrl_if #(
   parameter int NUM_MODULES = 3
);
   import bomb_pkg::*;

   state_t                 current_state;
   logic [NUM_MODULES-1:0] module_activated;
   logic [NUM_MODULES-1:0] module_failed;
   logic [NUM_MODULES-1:0] module_solved;

   modport master (
      output current_state,
      input  module_activated,
      input  module_failed,
      input  module_solved
   );

   modport slave (
      input  current_state,
      output module_activated,
      output module_failed,
      output module_solved
   );

endinterface

// File: rtl/bomb_countdown.sv
// rtl/bomb_countdown.sv - tick divider plus seconds counter for the game timer
// tick fires on the last divider count; expired flags the final second.
module bomb_countdown
   import bomb_pkg::*;
#(
   parameter int CNT_W = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [TIME_W-1:0] load_val,
   input  logic              run,
   input  logic [CNT_W:0]    period,
   output logic [TIME_W-1:0] time_left,
   output logic              tick,
   output logic              expired
);

   localparam logic [CNT_W:0]    PERIOD_ONE = (CNT_W+1)'(1);
   localparam logic [TIME_W-1:0] TIME_ONE   = TIME_W'(1);

   logic [CNT_W-1:0] tick_cnt;

   // >= rather than == so a shrunken period forces a wrap right away
   assign tick    = run && ({1'b0, tick_cnt} >= (period - PERIOD_ONE));
   assign expired = (time_left == TIME_ONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         time_left <= '0;
         tick_cnt  <= '0;
      end else if (load) begin
         time_left <= load_val;
         tick_cnt  <= '0;
      end else if (run) begin
         if (tick) begin
            tick_cnt <= '0;
            if (time_left != '0)
               time_left <= time_left - TIME_ONE;
         end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/bomb_game_ctrl.sv
// rtl/bomb_game_ctrl.sv - bomb game sequencer: activation, timer, strikes, win/lose
// Optional STRIKE_SPEEDUP_EN shortens the tick period by a quarter per strike.
module bomb_game_ctrl
   import bomb_pkg::*;
#(
   parameter int NUM_MODULES  = 3,
   parameter int MAX_STRIKES  = 3,
   parameter int TICK_DIV     = 50000000,
   parameter int GAME_SECONDS = 300,
   parameter int ACT_WAIT     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   bomb_game_ctrl_if.master       bus,
   output logic [TIME_W-1:0]      time_left,
   output logic [STRIKE_W-1:0]    strikes,
   output logic                   strike_pulse,
   output logic [NUM_MODULES-1:0] solved_mask,
   output logic                   game_won,
   output logic                   game_lost
);

   localparam int                  CNT_W       = $clog2(TICK_DIV);
   localparam int                  WAIT_W      = $clog2(ACT_WAIT + 1);
   localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(ACT_WAIT - 1);
   localparam logic [STRIKE_W-1:0] STRIKE_CAP  = STRIKE_W'(MAX_STRIKES);
   localparam logic [CNT_W:0]      PERIOD_BASE = (CNT_W+1)'(TICK_DIV);

   state_t                 state_q, state_d;
   logic                   start_q, start_edge;
   logic [NUM_MODULES-1:0] ack_mask, ack_d, solved_d, fail_live;
   logic [WAIT_W-1:0]      wait_cnt, wait_d;
   logic [STRIKE_W-1:0]    strikes_d;
   logic                   pulse_d;
   int                     new_cnt, strike_sum;
   logic                   cd_load, cd_run, cd_tick, cd_expired;
   logic [CNT_W:0]         period;

   assign start_edge        = start & ~start_q;
   assign cd_load           = (state_q == ST_IDLE);
   assign cd_run            = (state_q == ST_ACTIVATED);
   assign bus.current_state = state_q;
   assign game_won          = (state_q == ST_DEFUSED);
   assign game_lost         = (state_q == ST_EXPLODED);

`ifdef STRIKE_SPEEDUP_EN
   localparam logic [CNT_W:0] PERIOD_STEP = (CNT_W+1)'(TICK_DIV >> 2);
   assign period = PERIOD_BASE - PERIOD_STEP * {{(CNT_W-1){1'b0}}, strikes};
`else
   assign period = PERIOD_BASE;
`endif

   bomb_countdown #(.CNT_W(CNT_W)) u_countdown (
      .clk       (clk),
      .rst       (rst),
      .load      (cd_load),
      .load_val  (TIME_W'(GAME_SECONDS)),
      .run       (cd_run),
      .period    (period),
      .time_left (time_left),
      .tick      (cd_tick),
      .expired   (cd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         start_q      <= 1'b0;
         ack_mask     <= '0;
         wait_cnt     <= '0;
         solved_mask  <= '0;
         strikes      <= '0;
         strike_pulse <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start;
         ack_mask     <= ack_d;
         wait_cnt     <= wait_d;
         solved_mask  <= solved_d;
         strikes      <= strikes_d;
         strike_pulse <= pulse_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_mask;
      wait_d    = wait_cnt;
      solved_d  = solved_mask;
      strikes_d = strikes;
      pulse_d   = 1'b0;

      // failures from modules already solved (or absent) never count
      fail_live = bus.module_failed & ~solved_mask;
      new_cnt   = 0;
      for (int i = 0; i < NUM_MODULES; i++)
         new_cnt += int'(fail_live[i]);
      strike_sum = int'(strikes) + new_cnt;

      case (state_q)
         ST_IDLE: begin
            ack_d     = '0;
            wait_d    = '0;
            solved_d  = '0;
            strikes_d = '0;
            if (start_edge)
               state_d = ST_ACTIVATING;
         end
         ST_ACTIVATING: begin
            ack_d  = ack_mask | bus.module_activated;
            wait_d = wait_cnt + WAIT_W'(1);
            if ((&ack_mask) || (wait_cnt == WAIT_LAST)) begin
               state_d  = ST_ACTIVATED;
               solved_d = solved_mask | ~ack_d;
            end
         end
         ST_ACTIVATED: begin
            solved_d  = solved_mask | bus.module_solved;
            strikes_d = (strike_sum >= MAX_STRIKES) ? STRIKE_CAP : STRIKE_W'(strike_sum);
            pulse_d   = (new_cnt > 0);
            if (strike_sum >= MAX_STRIKES)
               state_d = ST_EXPLODED;
            else if (cd_tick && cd_expired)
               state_d = ST_EXPLODED;
            else if (&solved_d)
               state_d = ST_DEFUSED;
         end
         ST_DEFUSED, ST_EXPLODED: begin
            if (start_edge)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// tb/tb_bomb_game_ctrl.sv - directed vectors for bomb_game_ctrl (TICK_DIV=4, GAME_SECONDS=5)
module tb_bomb_game_ctrl;
   import bomb_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [9:0]    time_left;
   logic [1:0]    strikes;
   logic          strike_pulse;
   logic [2:0]    solved_mask;
   logic          game_won;
   logic          game_lost;

   int n_vec = 0;
   int n_bad = 0;

   bomb_game_ctrl_if #(.NUM_MODULES(3)) bus ();

   bomb_game_ctrl #(
      .NUM_MODULES  (3),
      .MAX_STRIKES  (3),
      .TICK_DIV     (4),
      .GAME_SECONDS (5),
      .ACT_WAIT     (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .bus          (bus),
      .time_left    (time_left),
      .strikes      (strikes),
      .strike_pulse (strike_pulse),
      .solved_mask  (solved_mask),
      .game_won     (game_won),
      .game_lost    (game_lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_game();
      start = 1'b0;
      step(1);
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      bus.module_activated = 3'b000;
      bus.module_failed    = 3'b000;
      bus.module_solved    = 3'b000;
      #23;
      check("rst_state",  32'(bus.current_state), 0);
      check("rst_time",   32'(time_left), 0);
      check("rst_strikes",32'(strikes), 0);
      check("rst_won",    32'(game_won), 0);
      check("rst_lost",   32'(game_lost), 0);
      rst = 1'b1;
      step(1);
      check("idle_time",  32'(time_left), 5);

      // all three modules ack in the first ACTIVATING cycle
      start_game();
      check("act_c1", 32'(bus.current_state), 1);
      bus.module_activated = 3'b111;
      step(1);
      check("act_c2", 32'(bus.current_state), 1);
      step(1);
      check("acted", 32'(bus.current_state), 2);
      check("acted_time", 32'(time_left), 5);
      check("acted_mask", 32'(solved_mask), 0);

      // solved flags accumulate, DEFUSED after the last one
      bus.module_solved = 3'b001;
      step(1);
      check("solv_1", 32'(solved_mask), 1);
      bus.module_solved = 3'b010;
      step(1);
      check("solv_2", 32'(solved_mask), 3);
      bus.module_solved = 3'b100;
      step(1);
      check("defused", 32'(bus.current_state), 3);
      check("won", 32'(game_won), 1);
      bus.module_solved = 3'b000;
      step(6);
      check("frozen_time", 32'(time_left), 5);
      start = 1'b1;
      step(1);
      check("def_to_idle", 32'(bus.current_state), 0);
      check("won_clr", 32'(game_won), 0);
      step(3);
      check("start_held", 32'(bus.current_state), 0);

      // modules 0,1 ack only: timeout after 16 ACTIVATING cycles
      bus.module_activated = 3'b000;
      start_game();
      bus.module_activated = 3'b011;
      step(14);
      check("to_c15", 32'(bus.current_state), 1);
      step(1);
      check("to_c16", 32'(bus.current_state), 1);
      step(1);
      check("to_acted", 32'(bus.current_state), 2);
      check("to_mask", 32'(solved_mask), 4);

      // two simultaneous failures, masked failure, then third strike
      bus.module_failed = 3'b011;
      step(1);
      check("stk2", 32'(strikes), 2);
      check("stk2_pulse", 32'(strike_pulse), 1);
      bus.module_failed = 3'b000;
      step(1);
      check("pulse_once", 32'(strike_pulse), 0);
      bus.module_failed = 3'b100;
      step(1);
      check("absent_fail", 32'(strikes), 2);
      check("absent_pulse", 32'(strike_pulse), 0);
      bus.module_failed = 3'b001;
      step(1);
      check("stk3", 32'(strikes), 3);
      check("stk3_boom", 32'(bus.current_state), 4);
      check("stk3_lost", 32'(game_lost), 1);
      check("stk3_time", 32'(time_left), 4);
      bus.module_failed = 3'b011;
      step(1);
      check("boom_nostk", 32'(strikes), 3);
      check("boom_nopulse", 32'(strike_pulse), 0);
      bus.module_failed = 3'b000;
      start = 1'b1;
      step(1);
      check("boom_to_idle", 32'(bus.current_state), 0);

      // no activity: time runs out after 20 ACTIVATED cycles
      bus.module_activated = 3'b000;
      start_game();
      bus.module_activated = 3'b111;
      step(2);
      check("tm_acted", 32'(bus.current_state), 2);
      step(3);
      check("tm_c4", 32'(time_left), 5);
      step(1);
      check("tm_c5", 32'(time_left), 4);
      step(15);
      check("tm_c20", 32'(time_left), 1);
      check("tm_c20_st", 32'(bus.current_state), 2);
      step(1);
      check("tm_boom", 32'(bus.current_state), 4);
      check("tm_zero", 32'(time_left), 0);
      step(5);
      check("tm_hold0", 32'(time_left), 0);
      start = 1'b1;
      step(1);
      check("tm_idle", 32'(bus.current_state), 0);

      // one strike, then asynchronous reset mid-cycle
      start_game();
      step(2);
      check("rs_acted", 32'(bus.current_state), 2);
      bus.module_failed = 3'b001;
      step(1);
      check("rs_stk1", 32'(strikes), 1);
      check("rs_pulse", 32'(strike_pulse), 1);
      bus.module_failed = 3'b000;
      step(2);
`ifdef STRIKE_SPEEDUP_EN
      check("rs_speedup", 32'(time_left), 4);
`else
      check("rs_nospeed", 32'(time_left), 5);
`endif
      #2;
      rst = 1'b0;
      #1;
      check("ar_state", 32'(bus.current_state), 0);
      check("ar_strikes", 32'(strikes), 0);
      check("ar_time", 32'(time_left), 0);
      check("ar_mask", 32'(solved_mask), 0);
      check("ar_pulse", 32'(strike_pulse), 0);
      rst = 1'b1;
      step(1);
      check("ar_reload", 32'(time_left), 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bomb_game_ctrl.md
Name: bomb_game_ctrl

Overview:
Top-level game sequencer that drives the shared current_state bus to every puzzle module (Wires, etc.) and consumes their activated / module_failed / module_solved handshake outputs. It owns the activation handshake, the countdown timer, the strike counter and the win/lose decision. It sits between the player start button / display logic and the array of puzzle modules.

Parameters:
NUM_MODULES, 3, number of puzzle modules on the bus
MAX_STRIKES, 3, strike count that explodes the bomb (1..3)
TICK_DIV, 50000000, clk cycles per countdown second (>=4)
GAME_SECONDS, 300, initial countdown value in seconds (<=1023)
ACT_WAIT, 16, max cycles spent in ACTIVATING waiting for acks

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  synchronous player start/restart level; the block uses its rising edge
module_activated  in  NUM_MODULES  per-module activated acks
module_failed  in  NUM_MODULES  per-module wrong-action pulses
module_solved  in  NUM_MODULES  per-module solved flags
current_state  out  3  broadcast state: 000 IDLE, 001 ACTIVATING, 010 ACTIVATED, 011 DEFUSED, 100 EXPLODED
time_left  out  10  remaining seconds
strikes  out  2  strikes so far (saturating)
strike_pulse  out  1  one-cycle pulse per cycle in which >=1 strike is added
solved_mask  out  NUM_MODULES  sticky per-module solved status
game_won  out  1  high in DEFUSED
game_lost  out  1  high in EXPLODED

Behaviour:
- Reset (async, rst=0): current_state=IDLE, time_left=0, strikes=0, strike_pulse=0, solved_mask=0, game_won=0, game_lost=0, internal ack mask/counters=0. Reset mid-game aborts immediately. Modules on the bus see IDLE on the first clk edge after release.
- start edge: a registered copy of start is kept. The edge is start & ~start_q.
- IDLE:
  - Start edge -> ACTIVATING on the next cycle.
  - Clear ack_mask, solved_mask and strikes.
  - Load time_left=GAME_SECONDS and tick_cnt=0.
- ACTIVATING:
  - Each cycle: ack_mask |= module_activated; wait_cnt increments.
  - When ack_mask is all ones, or wait_cnt==ACT_WAIT-1, go to ACTIVATED.
  - Modules that never acked are OR'd into solved_mask at that transition; they are treated as absent.
- ACTIVATED:
  - tick_cnt counts 0..TICK_DIV-1. On the wrap, time_left decrements.
  - solved_mask |= module_solved each cycle.
  - new_strikes = popcount(module_failed & ~solved_mask) in the current cycle. Simultaneous failures each count.
  - strikes is updated with a saturating add, capped at MAX_STRIKES. strike_pulse=1 in the following cycle iff new_strikes>0.
  - Exit priority, all decided in the same cycle:
    1. strikes+new_strikes >= MAX_STRIKES -> EXPLODED.
    2. time_left==1 at a tick wrap (decrement to 0) -> EXPLODED.
    3. (solved_mask|module_solved) all ones -> DEFUSED.
  - Latency: a failure at cycle t gives strikes/strike_pulse updated and any EXPLODED state visible at t+1.
- DEFUSED / EXPLODED:
  - Timer frozen. game_won or game_lost held high.
  - Module inputs are ignored; no strike_pulse is generated.
  - Start edge -> IDLE; a second start edge starts a new game.
- time_left never underflows; it stays 0 in EXPLODED.
- start held high produces only one edge.
- Illegal current_state encodings -> IDLE.

Optional Feature:
STRIKE_SPEEDUP_EN:
- Defined: the tick period shrinks with strikes, tick_period = TICK_DIV - (TICK_DIV>>2)*strikes (1 strike = 3/4 period, 2 strikes = 1/2 period). tick_cnt compares against the current period. If a strike lands with tick_cnt >= the new period, a wrap is forced on the next cycle.
- Undefined: the period is fixed at TICK_DIV.

Decomposition:
- Shared package bomb_pkg holds:
  - state constants ST_IDLE, ST_ACTIVATING, ST_ACTIVATED, ST_DEFUSED, ST_EXPLODED (3-bit);
  - width constants TIME_W=10, STRIKE_W=2.
  - Puzzle modules adopt the same encodings.
- One sub-module, bomb_countdown, holds the tick divider plus seconds counter.
  - Inputs: load, load_val, run, period.
  - Outputs: time_left, tick, expired.

Test Plan (NUM_MODULES=3, TICK_DIV=4, GAME_SECONDS=5, ACT_WAIT=16, MAX_STRIKES=3):
- Start pulse with all 3 modules acking the cycle after ACTIVATING -> ACTIVATING for 2 cycles, then ACTIVATED; time_left=5.
- Only modules 0,1 ack -> ACTIVATED after 16 ACTIVATING cycles; solved_mask=3'b100.
- module_solved pulses to 3'b001, then 3'b010, then 3'b100 -> solved_mask accumulates; DEFUSED one cycle after the last; game_won=1, timer frozen.
- module_failed=3'b011 in one cycle, then 3'b100 -> strikes=2 with a single strike_pulse, then strikes=3; EXPLODED one cycle after the second failure.
- No activity -> time_left decrements every 4 cycles; EXPLODED 20 cycles into ACTIVATED with time_left=0; start edge -> IDLE.
- rst low during ACTIVATED with strikes=1 -> all outputs 0 and IDLE immediately (asynchronous). With STRIKE_SPEEDUP_EN defined, 1 strike -> ticks every 3 cycles.
